// File: rtl/conv3x3_acc_stream.sv
// conv3x3_acc_stream
//   Producer end of the requantization path. Multiplies a stream of signed
//   pixel/weight tap pairs and accumulates the TAPS products of one window,
//   plus a per-window bias, into a signed ACC_W-bit sum. Each finished sum is
//   presented on TEMP through a single-entry valid/ready output slot.
//
//   Optional feature: define CONV_ACC_RELU_EN to clamp negative sums to zero
//   when TEMP is loaded. Counting and timing are unchanged.
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous reset, active-high
//   IN_VALID   tap pair valid
//   IN_READY   block can accept a tap
//   PIX, WGT   signed pixel / weight (DATA_W)
//   BIAS       signed bias (BIAS_W), sampled only with tap 0 of a window
//   OUT_VALID  TEMP holds a finished window sum
//   OUT_READY  downstream consumes TEMP
//   TEMP       signed window sum (ACC_W)
//   WIN_CNT    windows delivered, wraps modulo 2^CNT_W
module conv3x3_acc_stream #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 64,
    parameter int BIAS_W = 32,
    parameter int TAPS   = 9,
    parameter int CNT_W  = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic signed [DATA_W-1:0] PIX,
    input  logic signed [DATA_W-1:0] WGT,
    input  logic signed [BIAS_W-1:0] BIAS,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic signed [ACC_W-1:0]  TEMP,
    output logic [CNT_W-1:0]         WIN_CNT
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [TAP_W-1:0] tap_cnt;
    logic             accept;
    logic             tap_first;
    logic             tap_last;
    logic             slot_free;
    logic             load;

    logic signed [PROD_W-1:0] pix_ext;
    logic signed [PROD_W-1:0] wgt_ext;

    logic signed [PROD_W-1:0] prod_p0;
    logic signed [BIAS_W-1:0] bias_p0;
    logic                     vld_p0;
    logic                     first_p0;
    logic                     last_p0;

    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc_p1;
    logic                     done_p1;

    // Output clamp applied as TEMP is loaded.
    function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v);
`ifdef CONV_ACC_RELU_EN
        return v[ACC_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign accept    = IN_VALID & IN_READY;
    assign tap_first = (tap_cnt == '0);
    assign tap_last  = (tap_cnt == TAP_LAST);
    // The slot may be reloaded on the same edge that the consumer empties it.
    assign slot_free = !OUT_VALID || OUT_READY;

    assign pix_ext  = {{DATA_W{PIX[DATA_W-1]}}, PIX};
    assign wgt_ext  = {{DATA_W{WGT[DATA_W-1]}}, WGT};
    assign prod_ext = {{(ACC_W - PROD_W){prod_p0[PROD_W-1]}}, prod_p0};
    assign bias_ext = {{(ACC_W - BIAS_W){bias_p0[BIAS_W-1]}}, bias_p0};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // S_IDLE only exists so that IN_READY rises one edge after reset release.
    always_comb begin
        state_next = state;
        IN_READY   = 1'b0;
        load       = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_ACCUM;
            end
            S_ACCUM: begin
                IN_READY = 1'b1;
                if (IN_VALID && tap_last) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (done_p1 && slot_free) begin
                    load       = 1'b1;
                    state_next = S_ACCUM;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tap_cnt <= '0;
        end else if (load) begin
            tap_cnt <= '0;
        end else if (accept) begin
            tap_cnt <= tap_last ? '0 : tap_cnt + 1'b1;
        end
    end

    // ---- stage p0: product, window tags, bias capture ----
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prod_p0  <= '0;
            bias_p0  <= '0;
            vld_p0   <= 1'b0;
            first_p0 <= 1'b0;
            last_p0  <= 1'b0;
        end else begin
            vld_p0 <= accept;
            if (accept) begin
                prod_p0  <= pix_ext * wgt_ext;
                first_p0 <= tap_first;
                last_p0  <= tap_last;
                if (tap_first) begin
                    bias_p0 <= BIAS;
                end
            end
        end
    end

    // ---- stage p1: accumulate; done_p1 marks a complete window sum ----
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_p1  <= '0;
            done_p1 <= 1'b0;
        end else begin
            if (vld_p0) begin
                acc_p1 <= first_p0 ? (bias_ext + prod_ext) : (acc_p1 + prod_ext);
            end
            if (vld_p0 && last_p0) begin
                done_p1 <= 1'b1;
            end else if (load) begin
                done_p1 <= 1'b0;
            end
        end
    end

    // ---- output slot ----
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            TEMP      <= '0;
            OUT_VALID <= 1'b0;
            WIN_CNT   <= '0;
        end else if (load) begin
            TEMP      <= relu(acc_p1);
            OUT_VALID <= 1'b1;
            WIN_CNT   <= WIN_CNT + 1'b1;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv3x3_acc_stream.sv
// Directed bench for conv3x3_acc_stream: reset state, single windows,
// gapped input, output backpressure, mid-window reset, back-to-back windows.
module tb_conv3x3_acc_stream;

    logic               CLK;
    logic               RST;
    logic               IN_VALID;
    logic               IN_READY;
    logic signed [7:0]  PIX;
    logic signed [7:0]  WGT;
    logic signed [31:0] BIAS;
    logic               OUT_VALID;
    logic               OUT_READY;
    logic signed [63:0] TEMP;
    logic [15:0]        WIN_CNT;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    conv3x3_acc_stream dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .PIX       (PIX),
        .WGT       (WGT),
        .BIAS      (BIAS),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .TEMP      (TEMP),
        .WIN_CNT   (WIN_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one tap and hold it until an edge accepts it; returns at posedge+1.
    task automatic send_tap(input logic signed [7:0] p, input logic signed [7:0] w,
                            input logic signed [31:0] b);
        int  n;
        bit  ok;
        PIX      = p;
        WGT      = w;
        BIAS     = b;
        IN_VALID = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 60) begin
            @(negedge CLK);
            ok = IN_READY;
            @(posedge CLK);
            #1;
            n++;
        end
        if (!ok) check("tap_timeout", {63'd0, IN_READY}, 64'd1);
    endtask

    // Bias is driven only on tap 0; later taps carry a decoy bias.
    task automatic send_window(input logic signed [7:0] p, input logic signed [7:0] w,
                               input logic signed [31:0] b, input bit gap, input bit keep);
        for (int i = 0; i < 9; i++) begin
            send_tap(p, w, (i == 0) ? b : ~b);
            if (gap && i < 8) begin
                IN_VALID = 1'b0;
                @(posedge CLK);
                #1;
            end
        end
        if (!keep) IN_VALID = 1'b0;
    endtask

    // Wait (bounded) for OUT_VALID at negedges; n = negedges examined.
    task automatic wait_out(input string tag, input logic [63:0] et, input logic [15:0] ec,
                            output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!OUT_VALID && n < 80);
        check({tag, "_valid"}, {63'd0, OUT_VALID}, 64'd1);
        check({tag, "_temp"}, TEMP, et);
        check({tag, "_cnt"}, {48'd0, WIN_CNT}, {48'd0, ec});
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check("rst_in_ready", {63'd0, IN_READY}, 64'd0);
        check("rst_out_valid", {63'd0, OUT_VALID}, 64'd0);
        check("rst_temp", TEMP, 64'd0);
        check("rst_win_cnt", {48'd0, WIN_CNT}, 64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_rel_in_ready", {63'd0, IN_READY}, 64'd1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int n;
        int t_prev;
        logic signed [63:0] exp2;

        RST       = 1'b1;
        IN_VALID  = 1'b0;
        PIX       = '0;
        WGT       = '0;
        BIAS      = '0;
        OUT_READY = 1'b1;

        // Power-on reset state
        repeat (3) @(negedge CLK);
        check("init_in_ready", {63'd0, IN_READY}, 64'd0);
        check("init_out_valid", {63'd0, OUT_VALID}, 64'd0);
        check("init_temp", TEMP, 64'd0);
        check("init_win_cnt", {48'd0, WIN_CNT}, 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("init_rel_in_ready", {63'd0, IN_READY}, 64'd1);
        @(posedge CLK);
        #1;

        // T1: all ones, latency and single-cycle valid
        send_window(8'sd1, 8'sd1, 32'sd0, 1'b0, 1'b0);
        wait_out("t1", 64'd9, 16'd1, n);
        check("t1_latency", 64'(n - 1), 64'd2);
        @(negedge CLK);
        check("t1_valid_pulse", {63'd0, OUT_VALID}, 64'd0);

        // T2: extreme negative products plus negative bias
`ifdef CONV_ACC_RELU_EN
        exp2 = 64'sd0;
`else
        exp2 = 64'shFFFF_FFFF_FFFD_C47B;
`endif
        @(posedge CLK);
        #1;
        send_window(-8'sd128, 8'sd127, -32'sd5, 1'b0, 1'b0);
        wait_out("t2", exp2, 16'd2, n);

        // T3: IN_VALID toggling between taps
        @(posedge CLK);
        #1;
        send_window(8'sd1, 8'sd1, 32'sd0, 1'b1, 1'b0);
        wait_out("t3", 64'd9, 16'd3, n);

        // T4: backpressure with OUT_READY held low
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        send_window(8'sd1, 8'sd1, 32'sd0, 1'b0, 1'b0);
        wait_out("t4a", 64'd9, 16'd4, n);
        @(posedge CLK);
        #1;
        send_window(8'sd2, 8'sd3, 32'sd1, 1'b0, 1'b0);
        repeat (4) @(negedge CLK);
        check("t4_stall_in_ready", {63'd0, IN_READY}, 64'd0);
        check("t4_hold_valid", {63'd0, OUT_VALID}, 64'd1);
        check("t4_hold_temp", TEMP, 64'd9);
        check("t4_hold_cnt", {48'd0, WIN_CNT}, 64'd4);
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        @(negedge CLK);
        check("t4_swap_temp", TEMP, 64'd55);
        check("t4_swap_valid", {63'd0, OUT_VALID}, 64'd1);
        check("t4_swap_in_ready", {63'd0, IN_READY}, 64'd1);
        check("t4_swap_cnt", {48'd0, WIN_CNT}, 64'd5);
        repeat (2) @(negedge CLK);
        check("t4_held_temp", TEMP, 64'd55);

        // T5: reset in the middle of a window discards taps and bias
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) send_tap(8'sd7, 8'sd5, 32'sd100);
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        do_reset();
        send_window(8'sd1, 8'sd1, 32'sd0, 1'b0, 1'b0);
        wait_out("t5", 64'd9, 16'd1, n);

        // T6: five back-to-back windows, expected sum = 9*k*(-3) + 100*k = 73k
        do_reset();
        t_prev = 0;
        fork
            begin
                for (int k = 1; k <= 5; k++)
                    send_window(8'(k), -8'sd3, 32'(100 * k), 1'b0, 1'b1);
                IN_VALID = 1'b0;
            end
            begin
                for (int k = 1; k <= 5; k++) begin
                    wait_out($sformatf("t6_w%0d", k), 64'(73 * k), 16'(k), n);
                    if (k > 1) check($sformatf("t6_period%0d", k), 64'(cyc - t_prev), 64'd11);
                    t_prev = cyc;
                end
            end
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv3x3_acc_stream.md
Name: conv3x3_acc_stream

Overview:
- Producer end of the requantization path in the CNN_3_3 datapath.
- Takes a stream of signed 8-bit pixel/weight tap pairs and multiplies each pair.
- Accumulates the 9 products of one 3x3 window, plus a per-window bias, into a 64-bit signed sum.
- Presents each finished sum on TEMP with a valid/ready handshake to the downstream shift/saturate stage.

Parameters:
DATA_W, 8, signed width of PIX and WGT
ACC_W, 64, accumulator and TEMP width
BIAS_W, 32, signed bias width; sign-extended to ACC_W
TAPS, 9, taps per window (3x3)
CNT_W, 16, window counter width

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  asynchronous reset, active-high
IN_VALID  in  1  tap pair valid
IN_READY  out  1  block can accept a tap
PIX  in  DATA_W  signed pixel
WGT  in  DATA_W  signed weight
BIAS  in  BIAS_W  signed bias; sampled only with tap 0 of a window
OUT_VALID  out  1  TEMP holds a finished window sum
OUT_READY  in  1  downstream consumes TEMP
TEMP  out  ACC_W  signed window sum
WIN_CNT  out  CNT_W  number of windows delivered; wraps modulo 2^CNT_W

Behaviour:
- Reset (async, RST=1) clears everything:
  - IN_READY=0 while RST=1; it goes to 1 on the first edge after RST is released.
  - OUT_VALID=0, TEMP=0, WIN_CNT=0.
  - Tap counter, product stage and accumulator are cleared. A partial window is discarded.
- Tap transfer happens on any edge with IN_VALID & IN_READY. IN_VALID may drop between taps; gaps do not affect the result.
- Stage 1 (product): prod_q <= sext(PIX)*sext(WGT) as a signed 16-bit product. The stage carries a valid flag and a first/last tag.
- Stage 2 (accumulate):
  - First tap: acc <= sext(bias_q) + sext(prod_q). bias_q is captured with tap 0.
  - Other taps: acc <= acc + sext(prod_q).
  - Arithmetic is two's complement, modulo 2^ACC_W. No overflow is possible at default widths.
- FSM:
  - ACCUM: IN_READY=1. The tap counter counts 0..TAPS-1. Accepting tap TAPS-1 moves the FSM to DRAIN.
  - DRAIN: IN_READY=0. Wait for the last product to accumulate and for the output slot to be free. The slot is free when OUT_VALID=0, or when OUT_VALID & OUT_READY on the same edge. Then load TEMP, set OUT_VALID=1, increment WIN_CNT, clear the counter and return to ACCUM.
- Latency: OUT_VALID rises on the 2nd rising edge after the edge that accepted the last tap, provided the slot is free.
- Throughput: one window per TAPS+2 cycles with continuous input and OUT_READY=1.
- Output slot is single-entry:
  - TEMP is stable while OUT_VALID & !OUT_READY.
  - OUT_VALID falls on a consume edge unless a new sum loads on that same edge, in which case it stays 1 and TEMP updates.
- Backpressure:
  - A second window fully accumulates while the slot is occupied.
  - Its sum waits in acc, in DRAIN, with IN_READY=0.
  - No sum is ever dropped or overwritten.
- TAPS=1 is legal: every tap is both first and last.

Optional Feature:
- Macro: CONV_ACC_RELU_EN.
- Defined: when TEMP is loaded, a negative sum (MSB=1) is replaced by 0. Positive sums pass unchanged. WIN_CNT and timing are identical to the undefined case.
- Undefined: the signed sum passes through unmodified.

Test Plan:
- Reset release, then 9 taps PIX=1, WGT=1, BIAS=0, OUT_READY=1 -> OUT_VALID for 1 cycle, TEMP=64'd9, WIN_CNT=1, OUT_VALID 2 edges after the last tap.
- 9 taps PIX=-128, WGT=127, BIAS=-5 -> TEMP=64'hFFFF_FFFF_FFFD_C47B (-146309); with CONV_ACC_RELU_EN -> TEMP=0.
- Same window as test 1, with IN_VALID toggled 1/0 every cycle -> TEMP=9, identical to contiguous input.
- OUT_READY=0:
  - Send window A (all 1s, BIAS=0) -> TEMP=9 held.
  - Send window B (PIX=2, WGT=3, BIAS=1) -> IN_READY=0 after B's 9th tap, TEMP remains 9.
  - Pulse OUT_READY -> next edge TEMP=55, OUT_VALID stays 1, IN_READY=1.
- Assert RST after 4 taps of a window (BIAS=100), then send a fresh window of all 1s, BIAS=0 -> TEMP=9 (no stale taps or bias), WIN_CNT=1.
- 5 back-to-back windows, continuous IN_VALID, OUT_READY=1 -> results every 11 cycles, WIN_CNT 1..5, each TEMP correct.
